bird_physics: RTL and testbench
===============================

# bird_physics

Parametrised next-generation bird motion block for the flappy_bird game: tracks vertical position and signed velocity, integrates velocity on a programmable gravity tick, applies a velocity impulse on each new flap press, and detects floor crash. Sits between the debounced Flap key and the display/collision logic and replaces the fixed-step bird controller. It adds velocity with terminal speed, flap edge detection, an IDLE/FLY/CRASHED state machine and a Restart path.

## Interface
- Y_WIDTH, 4: position width; Y_MAX = 2^Y_WIDTH-1 is the floor row, 0 is the ceiling.
- Y_START, 8: spawn row, must be < Y_MAX.
- VEL_WIDTH, 4: signed velocity width.
- GRAVITY_RATE, 150: enabled cycles per physics step, ≥ 2.
- FLAP_VEL, 2: upward speed set by a flap, 1 ≤ FLAP_VEL ≤ 2^(VEL_WIDTH-1)-1.
- V_MAX, 3: terminal downward speed, same range as FLAP_VEL.
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset.
- Enable  in  1  game tick qualifier; when low, state, Y, Vel and counter hold.
- Flap  in  1  level flap request; only rising edges act.
- Restart  in  1  leave CRASHED; ignored in other states.
- Y  out  Y_WIDTH  bird row.
- Vel  out  VEL_WIDTH  signed velocity, positive = downward.
- Flying  out  1  high in FLY.
- Crashed  out  1  high in CRASHED.

## Operation
- States: IDLE, FLY, CRASHED. Reset (Reset=0 at a clock edge) → IDLE, Y=Y_START, Vel=0, gravity counter=0, Flying=0, Crashed=0, flap history register=0.
- Flap edge register samples Flap every clock, whether or not Enable is high. A flap event is Flap & ~Flap_q & Enable. Holding Flap high produces exactly one event.
- IDLE: Y and Vel hold. A flap event → FLY, Vel=-FLAP_VEL, counter=0.
- FLY: counter increments each Enable cycle.
  - When the counter reaches GRAVITY_RATE-1: physics step, then counter=0.
  - Step: sum = Y + Vel, computed signed in Y_WIDTH+2 bits.
  - sum < 0: Y=0 and Vel=0 (ceiling stop).
  - sum ≥ Y_MAX: Y=Y_MAX, Vel=0, go to CRASHED.
  - Otherwise: Y=sum, Vel=min(Vel+1, V_MAX).
- Flap event in FLY: Vel=-FLAP_VEL, counter=0, Y unchanged. If it coincides with a step cycle, the flap wins and no step occurs.
- CRASHED: everything frozen. Flap is ignored. Restart=1 with Enable=1 → IDLE, Y=Y_START, Vel=0, counter=0.
- Flying and Crashed are registered and decoded from the next state, so they change in the same cycle as the state.

## Timing
- All outputs are registered, and each update is visible the cycle after the triggering edge.
- Flap: Flap rises at edge k (Flap_q=0), so Vel=-FLAP_VEL after edge k. Y first moves GRAVITY_RATE enabled cycles later.
- Step period: exactly GRAVITY_RATE enabled cycles. Cycles with Enable low do not count.
- Reset mid-step or mid-crash: reset values take effect on the next edge. Reset has priority over every other input.
- Restart and a flap event in the same cycle while in CRASHED: go to IDLE only. The flap is not applied.

## Test plan
(Use GRAVITY_RATE=4, Y_START=8, FLAP_VEL=2, V_MAX=3, Y_WIDTH=4, Enable=1 unless noted.)
1. Reset low 1 cycle, then idle 20 cycles → Y=8, Vel=0, Flying=0, Crashed=0 throughout.
2. Single flap pulse from IDLE, then no input → Flying=1, Vel=-2. Y over successive steps every 4 cycles: 6, 5, 5, 6, 8, 11, 14, then 15 with Crashed=1, Flying=0 and Vel=0. Vel saturates at 3.
3. Hold Flap high 30 cycles → exactly one impulse; trajectory is identical to scenario 2.
4. Y_START=1, flap → first step gives Y=0, Vel=0. The next step gives Y=0, Vel=1. The step after that gives Y=1.
5. In FLY, toggle Enable low for 10 cycles → Y, Vel and counter hold. After re-enable, the step lands exactly 4 enabled cycles after the previous one. A flap pulse while Enable=0 has no effect.
6. In CRASHED: flap → no change. Restart=1 → IDLE, Y=8, Vel=0. Reset low during FLY mid-count → IDLE, Y=8, counter cleared on the next edge.

Source files
------------

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - bird vertical motion: gravity-ticked velocity integration,
// flap impulse on rising edge, ceiling stop and floor crash with IDLE/FLY/CRASHED control.
module bird_physics #(
  parameter int Y_WIDTH      = 4,
  parameter int Y_START      = 8,
  parameter int VEL_WIDTH    = 4,
  parameter int GRAVITY_RATE = 150,
  parameter int FLAP_VEL     = 2,
  parameter int V_MAX        = 3
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic                        Flap,
  input  logic                        Restart,
  output logic [Y_WIDTH-1:0]          Y,
  output logic signed [VEL_WIDTH-1:0] Vel,
  output logic                        Flying,
  output logic                        Crashed
);

  localparam int CW = (GRAVITY_RATE > 2) ? $clog2(GRAVITY_RATE) : 1;
  localparam int SW = Y_WIDTH + 2;

  localparam logic [CW-1:0]               CNT_LAST = CW'(GRAVITY_RATE - 1);
  localparam logic [Y_WIDTH-1:0]          Y_MAX_U  = {Y_WIDTH{1'b1}};
  localparam logic signed [SW-1:0]        Y_MAX_S  = $signed({2'b00, Y_MAX_U});
  localparam logic [Y_WIDTH-1:0]          Y_RESET  = Y_WIDTH'(Y_START);
  localparam logic signed [VEL_WIDTH-1:0] V_FLAP   = VEL_WIDTH'(-FLAP_VEL);
  localparam logic signed [VEL_WIDTH-1:0] V_TERM   = VEL_WIDTH'(V_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLY     = 2'd1,
    ST_CRASHED = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [Y_WIDTH-1:0]            y_q, y_d;
  logic signed [VEL_WIDTH-1:0]   vel_q, vel_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          flap_q;
  logic                          flying_q, crashed_q;
  logic                          flap_ev;
  logic signed [SW-1:0]          sum;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    flap_ev = Flap & ~flap_q & Enable;
    sum     = $signed({2'b00, y_q}) + SW'(vel_q);

    unique case (state_q)
      ST_IDLE: begin
        if (flap_ev) begin
          state_d = ST_FLY;
          vel_d   = V_FLAP;
          cnt_d   = '0;
        end
      end
      ST_FLY: begin
        // A flap on the step cycle pre-empts the step entirely.
        if (flap_ev) begin
          vel_d = V_FLAP;
          cnt_d = '0;
        end else if (Enable) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (sum < 0) begin
              y_d   = '0;
              vel_d = '0;
            end else if (sum >= Y_MAX_S) begin
              y_d     = Y_MAX_U;
              vel_d   = '0;
              state_d = ST_CRASHED;
            end else begin
              y_d   = sum[Y_WIDTH-1:0];
              vel_d = (vel_q >= V_TERM) ? V_TERM : vel_q + VEL_WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_CRASHED: begin
        if (Restart && Enable) begin
          state_d = ST_IDLE;
          y_d     = Y_RESET;
          vel_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      y_q       <= Y_RESET;
      vel_q     <= '0;
      cnt_q     <= '0;
      flap_q    <= 1'b0;
      flying_q  <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      cnt_q     <= cnt_d;
      flap_q    <= Flap;
      flying_q  <= (state_d == ST_FLY);
      crashed_q <= (state_d == ST_CRASHED);
    end
  end

  assign Y       = y_q;
  assign Vel     = vel_q;
  assign Flying  = flying_q;
  assign Crashed = crashed_q;

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - self-checking bench for bird_physics with a cycle model,
// a vector table, hand-written corner sequences and randomized stimulus.
module tb_bird_physics;
  localparam int GR    = 4;
  localparam int FV    = 2;
  localparam int VM    = 3;
  localparam int YMAX  = 15;

  logic Clock = 1'b0;
  logic Reset, Enable, Flap, Restart;
  logic [3:0]        y0, y1;
  logic signed [3:0] v0, v1;
  logic              f0, f1, c0, c1;

  always #5 Clock = ~Clock;

  bird_physics #(.Y_WIDTH(4), .Y_START(8), .VEL_WIDTH(4), .GRAVITY_RATE(GR),
                 .FLAP_VEL(FV), .V_MAX(VM)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Flap(Flap), .Restart(Restart),
    .Y(y0), .Vel(v0), .Flying(f0), .Crashed(c0));

  bird_physics #(.Y_WIDTH(4), .Y_START(1), .VEL_WIDTH(4), .GRAVITY_RATE(GR),
                 .FLAP_VEL(FV), .V_MAX(VM)) dut1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Flap(Flap), .Restart(Restart),
    .Y(y1), .Vel(v1), .Flying(f1), .Crashed(c1));

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = flying, 2 = crashed; one entry per DUT.
  int ys[2] = '{8, 1};
  int m_mode[2], m_y[2], m_v[2], m_ticks[2];
  bit m_prev[2];

  task automatic model_clock(input bit rst, input bit en, input bit fl, input bit rs);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_mode[i] = 0; m_y[i] = ys[i]; m_v[i] = 0; m_ticks[i] = 0; m_prev[i] = 0;
      end else begin
        bit ev;
        int s;
        ev = fl && !m_prev[i] && en;
        m_prev[i] = fl;
        if (m_mode[i] == 0) begin
          if (ev) begin m_mode[i] = 1; m_v[i] = -FV; m_ticks[i] = 0; end
        end else if (m_mode[i] == 1) begin
          if (ev) begin
            m_v[i] = -FV; m_ticks[i] = 0;
          end else if (en) begin
            m_ticks[i]++;
            if (m_ticks[i] == GR) begin
              m_ticks[i] = 0;
              s = m_y[i] + m_v[i];
              if (s < 0) begin m_y[i] = 0; m_v[i] = 0; end
              else if (s >= YMAX) begin m_y[i] = YMAX; m_v[i] = 0; m_mode[i] = 2; end
              else begin m_y[i] = s; m_v[i] = (m_v[i] + 1 > VM) ? VM : m_v[i] + 1; end
            end
          end
        end else begin
          if (rs && en) begin m_mode[i] = 0; m_y[i] = ys[i]; m_v[i] = 0; m_ticks[i] = 0; end
        end
      end
    end
  endtask

  task automatic expect_out(input string name, input int ay, input int av, input bit af,
                            input bit ac, input int ey, input int ev, input bit ef, input bit ec);
    checks++;
    if (ay != ey || av != ev || af != ef || ac != ec) begin
      failures++;
      $display("FAIL %s got y=%0d vel=%0d fly=%0b crash=%0b expected y=%0d vel=%0d fly=%0b crash=%0b",
               name, ay, av, af, ac, ey, ev, ef, ec);
    end
  endtask

  task automatic tick(input bit rst, input bit en, input bit fl, input bit rs);
    Reset = rst; Enable = en; Flap = fl; Restart = rs;
    @(posedge Clock);
    model_clock(rst, en, fl, rs);
    #1;
    expect_out("model0", int'(y0), int'(v0), f0, c0, m_y[0], m_v[0], m_mode[0] == 1, m_mode[0] == 2);
    expect_out("model1", int'(y1), int'(v1), f1, c1, m_y[1], m_v[1], m_mode[1] == 1, m_mode[1] == 2);
  endtask

  typedef struct {
    bit rst, en, fl, rs;
    int n;
    int ey, ev;
    bit ef, ec;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit fl, input bit rs, input int n,
                     input int ey, input int ev, input bit ef, input bit ec);
    vec_t v;
    v.rst = rst; v.en = 1'b1; v.fl = fl; v.rs = rs; v.n = n;
    v.ey = ey; v.ev = ev; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b1; Flap = 1'b0; Restart = 1'b0;
    @(negedge Clock);

    add(0, 0, 0, 1,  8,  0, 0, 0);
    add(1, 0, 0, 20, 8,  0, 0, 0);
    add(1, 1, 0, 1,  8, -2, 1, 0);
    add(1, 0, 0, 4,  6, -1, 1, 0);
    add(1, 0, 0, 4,  5,  0, 1, 0);
    add(1, 0, 0, 4,  5,  1, 1, 0);
    add(1, 0, 0, 4,  6,  2, 1, 0);
    add(1, 0, 0, 4,  8,  3, 1, 0);
    add(1, 0, 0, 4, 11,  3, 1, 0);
    add(1, 0, 0, 4, 14,  3, 1, 0);
    add(1, 0, 0, 4, 15,  0, 0, 1);
    add(1, 1, 0, 1, 15,  0, 0, 1);
    add(1, 0, 0, 3, 15,  0, 0, 1);
    add(1, 1, 1, 1,  8,  0, 0, 0);
    add(1, 1, 0, 2,  8,  0, 0, 0);
    add(1, 0, 0, 1,  8,  0, 0, 0);
    add(1, 1, 0, 1,  8, -2, 1, 0);
    add(1, 1, 0, 4,  6, -1, 1, 0);
    add(1, 1, 0, 4,  5,  0, 1, 0);
    add(1, 1, 0, 4,  5,  1, 1, 0);
    add(1, 1, 0, 4,  6,  2, 1, 0);
    add(1, 1, 0, 4,  8,  3, 1, 0);
    add(1, 1, 0, 4, 11,  3, 1, 0);
    add(1, 1, 0, 4, 14,  3, 1, 0);
    add(1, 1, 0, 5, 15,  0, 0, 1);
    add(0, 0, 0, 1,  8,  0, 0, 0);
    add(1, 1, 0, 1,  8, -2, 1, 0);
    add(1, 0, 0, 2,  8, -2, 1, 0);
    add(0, 0, 0, 1,  8,  0, 0, 0);
    add(1, 0, 0, 4,  8,  0, 0, 0);
    add(1, 1, 0, 1,  8, -2, 1, 0);
    add(1, 0, 0, 3,  8, -2, 1, 0);
    add(1, 0, 0, 1,  6, -1, 1, 0);

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].n; c++) tick(vecs[k].rst, vecs[k].en, vecs[k].fl, vecs[k].rs);
      expect_out($sformatf("vec%0d", k), int'(y0), int'(v0), f0, c0,
                 vecs[k].ey, vecs[k].ev, vecs[k].ef, vecs[k].ec);
    end

    // Ceiling stop on the Y_START=1 instance.
    tick(0, 1, 0, 0);
    tick(1, 1, 1, 0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    expect_out("ceil_step1", int'(y1), int'(v1), f1, c1, 0, 0, 1, 0);
    repeat (4) tick(1, 1, 0, 0);
    expect_out("ceil_step2", int'(y1), int'(v1), f1, c1, 0, 1, 1, 0);
    repeat (4) tick(1, 1, 0, 0);
    expect_out("ceil_step3", int'(y1), int'(v1), f1, c1, 1, 2, 1, 0);

    // Enable low freezes mid-count, and a flap pulse while disabled is lost.
    tick(0, 1, 0, 0);
    tick(1, 1, 1, 0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0);
    repeat (4) tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    repeat (5) tick(1, 0, 0, 0);
    expect_out("en_hold", int'(y0), int'(v0), f0, c0, 8, -2, 1, 0);
    tick(1, 1, 0, 0);
    expect_out("en_resume1", int'(y0), int'(v0), f0, c0, 8, -2, 1, 0);
    tick(1, 1, 0, 0);
    expect_out("en_resume2", int'(y0), int'(v0), f0, c0, 6, -1, 1, 0);

    // Randomized traffic checked cycle by cycle against the model.
    tick(0, 1, 0, 0);
    for (int r = 0; r < 3000; r++) begin
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
